// File: rtl/bus_pkg.sv
// Shared bus definitions: AXI response codes, arbiter FSM encoding, size helper.
package bus_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_WR_ADDR = 3'd1,
    ARB_WR_RESP = 3'd2,
    ARB_RD_ADDR = 3'd3,
    ARB_RD_DATA = 3'd4
  } arb_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // AxSIZE encoding for a full-width beat: log2 of the byte count.
  function automatic logic [2:0] AXI_SIZE_FROM_W(input int unsigned w);
    logic [2:0] s;
    s = 3'd0;
    for (int unsigned b = 1; b < w / 8; b = b * 2) s = s + 3'd1;
    return s;
  endfunction

endpackage

// File: rtl/axi_req_arbiter_if.sv
// AXI3 single-beat primary/secondary bundle (no rlast: beats are always single).
interface axi_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  int   w_j;
  logic w_found;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[w_j]) begin
        w_found     = 1'b1;
        o_gnt[w_j]  = 1'b1;
        o_idx       = IW'(w_j);
      end
    end
  end

  assign o_any = |i_req;
endmodule

// File: rtl/axi_req_arbiter.sv
// Round-robin share of one AXI3 secondary among NUM_REQ requesters,
// one outstanding single-beat transaction at a time.
module axi_req_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ-1:0][DATA_W/8-1:0]   req_wstrb,
  output logic [NUM_REQ-1:0]                 resp_valid,
  output logic [DATA_W-1:0]                  resp_rdata,
  output logic                               resp_err,
  axi_req_arbiter_if.master                  m_axi
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = DATA_W / 8;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  localparam logic [2:0] S_IDLE    = ARB_IDLE;
  localparam logic [2:0] S_WR_ADDR = ARB_WR_ADDR;
  localparam logic [2:0] S_WR_RESP = ARB_WR_RESP;
  localparam logic [2:0] S_RD_ADDR = ARB_RD_ADDR;
  localparam logic [2:0] S_RD_DATA = ARB_RD_DATA;

  logic [2:0]          r_state;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_gnt_idx;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [SW-1:0]       r_wstrb;
  logic                r_aw_vld, r_w_vld, r_ar_vld, r_bready, r_rready;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic [IW-1:0]       w_next_ptr;
  logic                w_aw_done, w_w_done;
  logic                w_unused_resp;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Pointer moves just past the requester that completed.
  assign w_next_ptr = (r_gnt_idx == LAST_IDX) ? '0 : r_gnt_idx + 1'b1;
  // A channel counts as done if it already handshook or is handshaking now.
  assign w_aw_done  = !r_aw_vld || m_axi.awready;
  assign w_w_done   = !r_w_vld  || m_axi.wready;
  // Only bit 1 of a response distinguishes error from OKAY/EXOKAY.
  assign w_unused_resp = ^{m_axi.bresp[0], m_axi.rresp[0]};

  // Transaction FSM; the cycle carrying resp_valid is skipped for arbitration
  // because the finishing requester still holds req_valid during it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_gnt_idx    <= '0;
      r_gnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_aw_vld     <= 1'b0;
      r_w_vld      <= 1'b0;
      r_ar_vld     <= 1'b0;
      r_bready     <= 1'b0;
      r_rready     <= 1'b0;
      r_resp_valid <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any && !(|r_resp_valid)) begin
            r_gnt_idx <= w_idx;
            r_gnt     <= w_gnt;
            r_addr    <= req_addr[w_idx];
            r_wdata   <= req_wdata[w_idx];
            r_wstrb   <= req_wstrb[w_idx];
            if (req_write[w_idx]) begin
              r_aw_vld <= 1'b1;
              r_w_vld  <= 1'b1;
              r_state  <= S_WR_ADDR;
            end else begin
              r_ar_vld <= 1'b1;
              r_state  <= S_RD_ADDR;
            end
          end
        end
        S_WR_ADDR: begin
          if (r_aw_vld && m_axi.awready) r_aw_vld <= 1'b0;
          if (r_w_vld  && m_axi.wready)  r_w_vld  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi.bvalid) begin
            r_resp_valid <= r_gnt;
            r_resp_err   <= m_axi.bresp[1];
            r_bready     <= 1'b0;
            r_rr_ptr     <= w_next_ptr;
            r_state      <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (m_axi.arready) begin
            r_ar_vld <= 1'b0;
            r_rready <= 1'b1;
            r_state  <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi.rvalid) begin
            r_resp_valid <= r_gnt;
            r_resp_rdata <= m_axi.rdata;
            r_resp_err   <= m_axi.rresp[1];
            r_rready     <= 1'b0;
            r_rr_ptr     <= w_next_ptr;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;

  assign m_axi.awvalid = r_aw_vld;
  assign m_axi.awaddr  = r_addr;
  assign m_axi.awlen   = 4'd0;
  assign m_axi.awsize  = AXI_SIZE_FROM_W(DATA_W);
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.wvalid  = r_w_vld;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.bready  = r_bready;
  assign m_axi.arvalid = r_ar_vld;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arlen   = 4'd0;
  assign m_axi.arsize  = AXI_SIZE_FROM_W(DATA_W);
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.rready  = r_rready;
endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter with a delay-programmable AXI secondary model.
module tb_axi_req_arbiter;
  import bus_pkg::*;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic aclk = 1'b0;
  logic areset;
  logic [NR-1:0]             req_valid, req_write;
  logic [NR-1:0][AW-1:0]     req_addr;
  logic [NR-1:0][DW-1:0]     req_wdata;
  logic [NR-1:0][DW/8-1:0]   req_wstrb;
  logic [NR-1:0]             resp_valid;
  logic [DW-1:0]             resp_rdata;
  logic                      resp_err;

  axi_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) axi();

  axi_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .m_axi      (axi)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          cyc;
    logic [NR-1:0] vec;
    logic [DW-1:0] rdata;
    logic        err;
  } ev_t;

  ev_t ev_q[$];
  int  n_cmp = 0, n_err = 0, cyc = 0;
  logic [NR-1:0] sticky;
  int  ar_first;
  logic [AW-1:0] ar_cap, aw_cap;
  logic [DW-1:0] wd_cap;
  logic [DW/8-1:0] ws_cap;
  bit  w_first, aw_seen, aw_unstable;

  // secondary model knobs
  int  aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]    bresp_v, rresp_v;
  logic [DW-1:0] rdata_v;
  int  aw_c, w_c, b_c, ar_c, r_c;
  bit  aw_got, w_got, ar_got;
  logic b_fire, r_fire;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr_mon();
    ev_q.delete();
    ar_first = -1; ar_cap = '0; aw_cap = '0; wd_cap = '0; ws_cap = '0;
    w_first = 0; aw_seen = 0; aw_unstable = 0;
  endtask

  // One cycle: sample on the falling edge, log responses, requesters drop on their pulse.
  task automatic tick();
    @(negedge aclk);
    cyc++;
    if (axi.arvalid) begin
      if (ar_first < 0) ar_first = cyc;
      ar_cap = axi.araddr;
    end
    if (axi.awvalid) begin
      if (aw_seen && axi.awaddr != aw_cap) aw_unstable = 1;
      aw_cap = axi.awaddr; aw_seen = 1;
    end
    if (axi.wvalid) begin wd_cap = axi.wdata; ws_cap = axi.wstrb; end
    if (axi.awvalid && !axi.wvalid) w_first = 1;
    if (|resp_valid) begin
      ev_q.push_back('{cyc, resp_valid, resp_rdata, resp_err});
      req_valid = req_valid & ~(resp_valid & ~sticky);
    end
  endtask

  task automatic wait_ev(input int n, input int budget, input string tag);
    int k = 0;
    while (ev_q.size() < n && k < budget) begin tick(); k++; end
    tick();
    chk({tag, "_nev"}, 64'(ev_q.size()), 64'(n));
  endtask

  // handshake observation at the active edge
  always @(posedge aclk) begin
    b_fire <= axi.bvalid && axi.bready;
    r_fire <= axi.rvalid && axi.rready;
  end

  // AXI secondary: each ready/valid raised after its programmed delay
  initial begin
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        axi.arready = 0; axi.rvalid = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
      end else begin
        if (axi.awready) axi.awready = 0;
        else if (axi.awvalid) begin
          if (aw_c >= aw_dly) begin axi.awready = 1; aw_got = 1; aw_c = 0; end else aw_c++;
        end
        if (axi.wready) axi.wready = 0;
        else if (axi.wvalid) begin
          if (w_c >= w_dly) begin axi.wready = 1; w_got = 1; w_c = 0; end else w_c++;
        end
        if (axi.arready) axi.arready = 0;
        else if (axi.arvalid) begin
          if (ar_c >= ar_dly) begin axi.arready = 1; ar_got = 1; ar_c = 0; end else ar_c++;
        end
        if (axi.bvalid) begin
          if (b_fire) axi.bvalid = 0;
        end else if (aw_got && w_got && !axi.awready && !axi.wready) begin
          if (b_c >= b_dly) begin
            axi.bvalid = 1; axi.bresp = bresp_v; aw_got = 0; w_got = 0; b_c = 0;
          end else b_c++;
        end
        if (axi.rvalid) begin
          if (r_fire) axi.rvalid = 0;
        end else if (ar_got && !axi.arready) begin
          if (r_c >= r_dly) begin
            axi.rvalid = 1; axi.rdata = rdata_v; axi.rresp = rresp_v; ar_got = 0; r_c = 0;
          end else r_c++;
        end
      end
    end
  end

  initial begin
    int t0, k;
    areset = 1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    sticky = '0; aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    bresp_v = OKAY; rresp_v = OKAY; rdata_v = '0;
    clr_mon();
    repeat (3) tick();

    // reset state
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_rdata", 64'(resp_rdata), 0);
    chk("rst_err", 64'(resp_err), 0);
    chk("rst_vld", 64'({axi.awvalid, axi.wvalid, axi.arvalid}), 0);
    chk("rst_rdy", 64'({axi.bready, axi.rready}), 0);
    chk("rst_state", 64'(dut.r_state), 0);
    areset = 0;
    tick();

    // 1: single read, slow secondary
    clr_mon(); ar_dly = 2; r_dly = 2; rdata_v = 32'hDEADBEEF;
    req_addr[0] = 32'h100; req_valid = 3'b001; t0 = cyc;
    wait_ev(1, 40, "t1");
    chk("t1_ar_lat", 64'(ar_first), 64'(t0 + 1));
    chk("t1_araddr", 64'(ar_cap), 64'h100);
    chk("t1_arsize", 64'(axi.arsize), 2);
    chk("t1_vec", 64'(ev_q[0].vec), 3'b001);
    chk("t1_rdata", 64'(ev_q[0].rdata), 64'hDEADBEEF);
    chk("t1_err", 64'(ev_q[0].err), 0);
    ar_dly = 0; r_dly = 0;

    // 2: write, data accepted before address
    clr_mon(); aw_dly = 3; w_dly = 0; b_dly = 2; bresp_v = OKAY;
    req_write = 3'b010; req_addr[1] = 32'h200; req_wdata[1] = 32'hA5A5A5A5; req_wstrb[1] = 4'hF;
    req_valid = 3'b010;
    wait_ev(1, 40, "t2");
    chk("t2_w_first", 64'(w_first), 1);
    chk("t2_aw_stable", 64'(aw_unstable), 0);
    chk("t2_awaddr", 64'(aw_cap), 64'h200);
    chk("t2_wdata", 64'(wd_cap), 64'hA5A5A5A5);
    chk("t2_wstrb", 64'(ws_cap), 4'hF);
    chk("t2_aw_attr", 64'({axi.awlen, axi.awsize, axi.awburst, axi.wlast}), 64'({4'd0, 3'd2, 2'b01, 1'b1}));
    chk("t2_vec", 64'(ev_q[0].vec), 3'b010);
    chk("t2_err", 64'(ev_q[0].err), 0);
    aw_dly = 0; b_dly = 0;

    // 4a: read SLVERR (pointer sits at 2)
    clr_mon(); rresp_v = SLVERR; rdata_v = 32'h0BADF00D;
    req_write = 3'b000; req_addr[2] = 32'h300; req_valid = 3'b100;
    wait_ev(1, 20, "t4a");
    chk("t4a_vec", 64'(ev_q[0].vec), 3'b100);
    chk("t4a_err", 64'(ev_q[0].err), 1);
    chk("t4a_rdata", 64'(ev_q[0].rdata), 64'h0BADF00D);
    rresp_v = OKAY;

    // 4b: write EXOKAY is not an error
    clr_mon(); bresp_v = EXOKAY;
    req_write = 3'b001; req_addr[0] = 32'h400; req_wdata[0] = 32'h12345678; req_wstrb[0] = 4'h3;
    req_valid = 3'b001;
    wait_ev(1, 20, "t4b");
    chk("t4b_vec", 64'(ev_q[0].vec), 3'b001);
    chk("t4b_err", 64'(ev_q[0].err), 0);
    bresp_v = OKAY;

    // 5: reset while waiting for the write response
    clr_mon(); b_dly = 20;
    req_write = 3'b010; req_valid = 3'b010;
    k = 0;
    while (!axi.bready && k < 20) begin tick(); k++; end
    chk("t5_in_wr_resp", 64'(axi.bready), 1);
    areset = 1; req_valid = '0;
    tick();
    chk("t5_vld", 64'({axi.awvalid, axi.wvalid, axi.arvalid}), 0);
    chk("t5_rdy", 64'({axi.bready, axi.rready}), 0);
    chk("t5_resp", 64'(resp_valid), 0);
    chk("t5_state", 64'(dut.r_state), 0);
    chk("t5_ptr", 64'(dut.r_rr_ptr), 0);
    tick();
    areset = 0; b_dly = 0;
    tick();
    chk("t5_no_resp", 64'(ev_q.size()), 0);

    // 3: all three continuously requesting, fresh pointer
    clr_mon(); rdata_v = 32'h5555AAAA;
    req_write = 3'b010; sticky = 3'b111; req_valid = 3'b111;
    wait_ev(6, 300, "t3");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_gnt%0d", i), 64'(ev_q[i].vec), 64'(3'b001 << (i % 3)));
      if (i > 0) chk($sformatf("t3_gap%0d", i), 64'(ev_q[i].cyc - ev_q[i-1].cyc > 1), 1);
    end
    sticky = '0;
    k = 0;
    while (req_valid != '0 && k < 100) begin tick(); k++; end
    chk("t3_drain", 64'(req_valid), 0);

    // 6: late bvalid with another request waiting
    clr_mon(); b_dly = 10;
    req_write = 3'b001; req_valid = 3'b001;
    tick(); tick();
    req_valid[1] = 1'b1;
    wait_ev(2, 100, "t6");
    chk("t6_first", 64'(ev_q[0].vec), 3'b001);
    chk("t6_second", 64'(ev_q[1].vec), 3'b010);
    chk("t6_ar_after", 64'(ar_first), 64'(ev_q[0].cyc + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
